// File: rtl/qspi_flash_arbiter_pkg.sv
// qspi_flash_pkg: shared FSM state type and flash bus widths for the QSPI flash arbiter
package qspi_flash_pkg;
  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_DATA_W = 8;
  typedef enum logic [1:0] {WAIT_SETUP, IDLE, READ, GAP} state_e;
endpackage

// File: rtl/qspi_flash_arbiter_if.sv
// qspi_flash_arbiter_if: requester request/response and flash reader signals; slave = arbiter, master = requesters + reader
interface qspi_flash_arbiter_if import qspi_flash_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int LEN_W = 8
);
  logic [NUM_PORTS-1:0] req_valid;
  logic [NUM_PORTS*FLASH_ADDR_W-1:0] req_addr;
  logic [NUM_PORTS*LEN_W-1:0] req_len;
  logic [NUM_PORTS-1:0] req_ready;
  logic [NUM_PORTS-1:0] abort;
  logic [NUM_PORTS-1:0] resp_valid;
  logic [FLASH_DATA_W-1:0] resp_data;
  logic resp_last;
  logic busy;
  logic [FLASH_ADDR_W-1:0] flash_addr;
  logic flash_do_read;
  logic flash_setup_done;
  logic flash_data_ready;
  logic [FLASH_DATA_W-1:0] flash_data;
  modport slave (
    input req_valid, req_addr, req_len, abort, flash_setup_done, flash_data_ready, flash_data,
    output req_ready, resp_valid, resp_data, resp_last, busy, flash_addr, flash_do_read
  );
  modport master (
    output req_valid, req_addr, req_len, abort, flash_setup_done, flash_data_ready, flash_data,
    input req_ready, resp_valid, resp_data, resp_last, busy, flash_addr, flash_do_read
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant from req_i searching up from a pointer; pointer moves past the winner on accept_i
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          accept_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);
  logic [IW-1:0] ptr_q;
  always_comb begin
    int j;
    gnt_idx_o = '0;
    gnt_valid_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % N;
      if (req_i[j]) begin
        gnt_idx_o = IW'(j);
        gnt_valid_o = 1'b1;
      end
    end
    gnt_o = gnt_valid_o ? N'(1) << gnt_idx_o : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (accept_i) ptr_q <= (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
  end
endmodule

// File: rtl/qspi_flash_arbiter.sv
// qspi_flash_arbiter: round-robin sharing of one QSPI flash reader; ports clk, rst, bus (slave: requests/responses and reader addr/do_read/data)
module qspi_flash_arbiter import qspi_flash_pkg::*; #(
  parameter int NUM_PORTS = 2,
  parameter int LEN_W = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  qspi_flash_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_PORTS);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  state_e state_q;
  logic [IW-1:0] owner_q;
  logic [FLASH_ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0] rem_q;
  logic [GW-1:0] gap_q;
  logic do_read_q;
  logic [NUM_PORTS-1:0] resp_valid_q;
  logic [FLASH_DATA_W-1:0] resp_data_q;
  logic resp_last_q;
  logic [NUM_PORTS-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic gnt_valid, accept, own_abort, byte_ok, burst_end;
  assign accept = state_q == IDLE && gnt_valid;
  assign own_abort = bus.abort[owner_q];
  assign byte_ok = state_q == READ && bus.flash_data_ready && !own_abort;
  assign burst_end = own_abort || (bus.flash_data_ready && rem_q == '0);
  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .clk(clk),
    .rst(rst),
    .req_i(bus.req_valid),
    .accept_i(accept),
    .gnt_o(gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_valid_o(gnt_valid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_SETUP;
      owner_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      gap_q <= '0;
      do_read_q <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q <= '0;
      resp_last_q <= 1'b0;
    end else begin
      resp_valid_q <= byte_ok ? NUM_PORTS'(1) << owner_q : '0;
      resp_last_q <= byte_ok && rem_q == '0;
      if (byte_ok) resp_data_q <= bus.flash_data;
      case (state_q)
        WAIT_SETUP: if (bus.flash_setup_done) state_q <= IDLE;
        IDLE: if (gnt_valid) begin
          owner_q <= gnt_idx;
          addr_q <= bus.req_addr[FLASH_ADDR_W*gnt_idx +: FLASH_ADDR_W];
          rem_q <= bus.req_len[LEN_W*gnt_idx +: LEN_W];
          do_read_q <= 1'b1;
          state_q <= READ;
        end
        READ: if (burst_end) begin
          do_read_q <= 1'b0;
          gap_q <= GW'(GAP_CYCLES - 1);
          state_q <= GAP;
        end else if (bus.flash_data_ready) rem_q <= rem_q - 1'b1;
        GAP: if (gap_q == '0) state_q <= IDLE; else gap_q <= gap_q - 1'b1;
        default: state_q <= WAIT_SETUP;
      endcase
    end
  end
  assign bus.req_ready = accept ? gnt : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_last = resp_last_q;
  assign bus.busy = state_q == READ || state_q == GAP;
  assign bus.flash_addr = addr_q;
  assign bus.flash_do_read = do_read_q;
endmodule

// File: tb/tb_qspi_flash_arbiter.sv
// tb_qspi_flash_arbiter: directed and randomized checks of qspi_flash_arbiter against a burst-level model
module tb_qspi_flash_arbiter;
  localparam int N = 2;
  localparam int LW = 8;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic rst;
  qspi_flash_arbiter_if #(.NUM_PORTS(N), .LEN_W(LW)) bus();
  qspi_flash_arbiter #(.NUM_PORTS(N), .LEN_W(LW), .GAP_CYCLES(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;
  bit m_setup, m_active;
  int m_owner, m_left, m_gap, m_ptr;
  logic [N-1:0] e_rv;
  logic [7:0] e_rd;
  logic e_rl;
  logic [23:0] e_addr;
  int rdy_cnt[N], rv_cnt[N], last_cnt, gap_ticks;
  int gq[$];
  logic [7:0] dq[$];
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic clear_stats();
    for (int p = 0; p < N; p++) begin
      rdy_cnt[p] = 0;
      rv_cnt[p] = 0;
    end
    last_cnt = 0;
    gap_ticks = 0;
    gq.delete();
    dq.delete();
  endtask
  function automatic int pick();
    for (int k = 0; k < N; k++) if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction
  task automatic tick();
    int g;
    logic [N-1:0] e_rdy;
    #1;
    g = (m_setup && !m_active && m_gap == 0) ? pick() : -1;
    e_rdy = '0;
    if (g >= 0) e_rdy[g] = 1'b1;
    if (cmp_en) begin
      chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
      chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv));
      chk("resp_data", 32'(bus.resp_data), 32'(e_rd));
      chk("resp_last", 32'(bus.resp_last), 32'(e_rl));
      chk("busy", 32'(bus.busy), 32'(m_active || m_gap > 0));
      chk("flash_do_read", 32'(bus.flash_do_read), 32'(m_active));
      chk("flash_addr", 32'(bus.flash_addr), 32'(e_addr));
    end
    for (int p = 0; p < N; p++) begin
      if (bus.req_ready[p]) begin
        rdy_cnt[p]++;
        gq.push_back(p);
      end
      if (bus.resp_valid[p]) begin
        rv_cnt[p]++;
        dq.push_back(bus.resp_data);
      end
    end
    if (bus.resp_last) last_cnt++;
    if (bus.busy && !bus.flash_do_read) gap_ticks++;
    e_rv = '0;
    e_rl = 1'b0;
    if (rst) begin
      m_setup = 0; m_active = 0; m_gap = 0; m_ptr = 0; m_owner = 0; m_left = 0;
      e_rd = '0; e_addr = '0;
    end else if (!m_setup) m_setup = bus.flash_setup_done;
    else if (m_active) begin
      if (bus.abort[m_owner]) begin
        m_active = 0;
        m_gap = GAP;
      end else if (bus.flash_data_ready) begin
        e_rv[m_owner] = 1'b1;
        e_rd = bus.flash_data;
        m_left--;
        if (m_left == 0) begin
          e_rl = 1'b1;
          m_active = 0;
          m_gap = GAP;
        end
      end
    end else if (m_gap > 0) m_gap--;
    else if (g >= 0) begin
      m_owner = g;
      m_left = int'(bus.req_len[LW*g +: LW]) + 1;
      e_addr = bus.req_addr[24*g +: 24];
      m_active = 1;
      m_ptr = (g + 1) % N;
    end
    @(negedge clk);
  endtask
  initial begin
    int nb, nb1;
    bit tr, ab;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_len = '0; bus.abort = '0;
    bus.flash_setup_done = 1'b0; bus.flash_data_ready = 1'b0; bus.flash_data = '0;
    clear_stats();
    @(negedge clk);
    tick();
    cmp_en = 1;
    tick();
    chk("rst_do_read", 32'(bus.flash_do_read), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr", 32'(bus.flash_addr), 0);
    rst = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_addr[23:0] = 24'h001000;
    bus.req_len[7:0] = 8'd3;
    repeat (20) tick();
    chk("gate_ready", 32'(rdy_cnt[0]), 0);
    chk("gate_busy", 32'(bus.busy), 0);
    bus.flash_setup_done = 1'b1;
    nb = 0; tr = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.flash_do_read && nb < 4) begin
        bus.flash_data_ready = 1'b1; bus.flash_data = 8'hA0 + 8'(nb); nb++;
      end else if (nb == 4 && !tr && bus.busy) begin
        bus.flash_data_ready = 1'b1; bus.flash_data = 8'hEE; tr = 1;
      end else bus.flash_data_ready = 1'b0;
      tick();
      if (rdy_cnt[0] != 0) bus.req_valid = '0;
    end
    chk("burst_accepts", 32'(rdy_cnt[0]), 1);
    chk("burst_pulses", 32'(rv_cnt[0]), 4);
    for (int i = 0; i < 4; i++) chk("burst_data", 32'(dq.size() > i ? dq[i] : 8'h00), 32'(8'hA0 + 8'(i)));
    chk("burst_last", 32'(last_cnt), 1);
    chk("burst_gap", 32'(gap_ticks), GAP);
    chk("trailing_sent", 32'(tr), 1);
    clear_stats();
    bus.req_addr = {24'h222222, 24'h111111};
    bus.req_len = '0;
    bus.req_valid = 2'b11;
    for (int c = 0; c < 30; c++) begin
      bus.flash_data_ready = bus.flash_do_read;
      bus.flash_data = 8'($urandom);
      tick();
    end
    bus.req_valid = '0;
    bus.flash_data_ready = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(gq.size() > i ? gq[i] : -1), 32'((i % 2 == 0) ? 1 : 0));
    chk("rr_count", 32'(gq.size() >= 7), 1);
    clear_stats();
    bus.req_len = {8'd15, 8'd0};
    bus.req_valid = 2'b10;
    nb1 = 0; ab = 0;
    for (int c = 0; c < 60; c++) begin
      bus.abort = '0;
      bus.flash_data_ready = bus.flash_do_read;
      bus.flash_data = 8'($urandom);
      if (bus.flash_do_read && nb1 == 2) bus.abort[0] = 1'b1;
      if (bus.flash_do_read && nb1 == 5 && !ab) begin
        bus.abort[1] = 1'b1; ab = 1;
      end else if (bus.flash_do_read && !ab) nb1++;
      tick();
      if (rdy_cnt[1] != 0 && rdy_cnt[0] == 0) bus.req_valid = 2'b01;
      if (rdy_cnt[0] != 0) bus.req_valid = '0;
    end
    bus.abort = '0;
    chk("abort_pulses", 32'(rv_cnt[1]), 5);
    chk("abort_port0", 32'(rv_cnt[0]), 1);
    chk("abort_last", 32'(last_cnt), 1);
    chk("abort_next", 32'(gq.size() > 1 ? gq[1] : -1), 0);
    clear_stats();
    bus.req_len[7:0] = 8'hFF;
    bus.req_valid = 2'b01;
    for (int c = 0; c < 1200 && rv_cnt[0] < 256; c++) begin
      bus.flash_data_ready = bus.flash_do_read && $urandom_range(0, 3) != 0;
      bus.flash_data = 8'($urandom);
      tick();
      if (rdy_cnt[0] != 0) bus.req_valid = '0;
    end
    bus.flash_data_ready = 1'b0;
    repeat (4) tick();
    chk("max_pulses", 32'(rv_cnt[0]), 256);
    chk("max_last", 32'(last_cnt), 1);
    clear_stats();
    bus.req_len[7:0] = 8'd7;
    bus.req_valid = 2'b01;
    for (int c = 0; c < 40 && rv_cnt[0] < 2; c++) begin
      bus.flash_data_ready = bus.flash_do_read;
      tick();
      if (rdy_cnt[0] != 0) bus.req_valid = '0;
    end
    chk("mid_pulses", 32'(rv_cnt[0]), 2);
    rst = 1'b1;
    tick();
    chk("mid_rv", 32'(bus.resp_valid), 0);
    chk("mid_last", 32'(bus.resp_last), 0);
    chk("mid_data", 32'(bus.resp_data), 0);
    chk("mid_do_read", 32'(bus.flash_do_read), 0);
    chk("mid_addr", 32'(bus.flash_addr), 0);
    chk("mid_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    clear_stats();
    bus.flash_data_ready = 1'b0;
    bus.req_len = '0;
    bus.req_valid = 2'b11;
    repeat (3) tick();
    chk("mid_regrant", 32'(gq.size() > 0 ? gq[0] : -1), 0);
    chk("mid_no_last", 32'(last_cnt), 0);
    for (int c = 0; c < 4000; c++) begin
      rst = $urandom_range(0, 999) == 0;
      bus.flash_setup_done = $urandom_range(0, 9) != 0;
      bus.req_valid = N'($urandom);
      for (int p = 0; p < N; p++) begin
        bus.req_addr[24*p +: 24] = 24'($urandom);
        bus.req_len[LW*p +: LW] = ($urandom_range(0, 15) == 0) ? LW'($urandom) : LW'($urandom_range(0, 5));
      end
      bus.abort = ($urandom_range(0, 29) == 0) ? N'($urandom) : '0;
      bus.flash_data_ready = $urandom_range(0, 2) != 0;
      bus.flash_data = 8'($urandom);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
